reg_file_param: RTL and testbench

//   Parametrised general-purpose register file for the SLC-3 datapath: 2**ADDR_W registers of

---
 rtl/reg_file_param.sv | 90 +++++++++
 tb/tb_reg_file_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised SLC-3 register file: one write port, two combinational read ports,
// optional write-to-read bypass, per-register dirty bits and a one-register-per-cycle clear sweep.
module reg_file_param #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     LD_REG,
    input  logic [WIDTH-1:0]         BUS_val,
    input  logic [ADDR_W-1:0]        DR_val,
    input  logic [ADDR_W-1:0]        SR1_val,
    input  logic [ADDR_W-1:0]        SR2_val,
    input  logic                     Clear_Req,
    output logic [WIDTH-1:0]         SR1_Out,
    output logic [WIDTH-1:0]         SR2_Out,
    output logic                     Clear_Busy,
    output logic                     Drop_Flag,
    output logic [(1<<ADDR_W)-1:0]   Dirty
);

    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  regs [NREGS];
    logic              bypass_ok;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            ptr       <= '0;
            Drop_Flag <= 1'b0;
            Dirty     <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A write in the same cycle as Clear_Req still lands; the sweep zeroes it later.
                    if (LD_REG) begin
                        regs[DR_val]  <= BUS_val;
                        Dirty[DR_val] <= 1'b1;
                    end
                    if (Clear_Req) begin
                        state     <= CLEAR;
                        ptr       <= '0;
                        Drop_Flag <= 1'b0;
                    end
                end
                CLEAR: begin
                    regs[ptr]  <= '0;
                    Dirty[ptr] <= 1'b0;
                    ptr        <= ptr + 1'b1;
                    if (LD_REG) begin
                        Drop_Flag <= 1'b1;
                    end
                    if (ptr == ADDR_W'(NREGS - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Clear_Busy = (state == CLEAR);

    // Bypass only applies when the write can actually happen, i.e. not while sweeping.
    assign bypass_ok = (BYPASS != 0) && (state == IDLE) && LD_REG;

    always_comb begin
        SR1_Out = regs[SR1_val];
        SR2_Out = regs[SR2_val];
        if (bypass_ok && (DR_val == SR1_val)) begin
            SR1_Out = BUS_val;
        end
        if (bypass_ok && (DR_val == SR2_val)) begin
            SR2_Out = BUS_val;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: a bypass and a non-bypass instance share stimulus,
// expected outputs come from a cycle model in the bench.
module tb_reg_file_param;

    logic        clk;
    logic        reset;
    logic        ld_reg;
    logic [15:0] bus_val;
    logic [2:0]  dr_val;
    logic [2:0]  sr1_val;
    logic [2:0]  sr2_val;
    logic        clear_req;

    logic [15:0] byp_sr1, byp_sr2, nob_sr1, nob_sr2;
    logic        byp_busy, nob_busy, byp_drop, nob_drop;
    logic [7:0]  byp_dirty, nob_dirty;

    reg_file_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(1)) dut_byp (
        .Clk(clk), .Reset(reset), .LD_REG(ld_reg), .BUS_val(bus_val), .DR_val(dr_val),
        .SR1_val(sr1_val), .SR2_val(sr2_val), .Clear_Req(clear_req),
        .SR1_Out(byp_sr1), .SR2_Out(byp_sr2), .Clear_Busy(byp_busy),
        .Drop_Flag(byp_drop), .Dirty(byp_dirty)
    );

    reg_file_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(0)) dut_nob (
        .Clk(clk), .Reset(reset), .LD_REG(ld_reg), .BUS_val(bus_val), .DR_val(dr_val),
        .SR1_val(sr1_val), .SR2_val(sr2_val), .Clear_Req(clear_req),
        .SR1_Out(nob_sr1), .SR2_Out(nob_sr2), .Clear_Busy(nob_busy),
        .Drop_Flag(nob_drop), .Dirty(nob_dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] n1;
        logic [15:0] n2;
        logic        busy;
        logic        drop;
        logic [7:0]  dirty;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int busy_count = 0;

    logic [15:0] m_regs [8];
    logic [7:0]  m_dirty;
    logic        m_busy;
    logic        m_drop;
    int          m_ptr;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_dirty = 8'h00;
        m_busy  = 1'b0;
        m_drop  = 1'b0;
        m_ptr   = 0;
    endtask

    // One clock cycle: drive, predict, sample mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input logic ld, input logic [2:0] dr, input logic [15:0] bus,
                                 input logic [2:0] s1, input logic [2:0] s2, input logic clr);
        exp_t e;
        exp_t got;
        @(negedge clk);
        ld_reg = ld; dr_val = dr; bus_val = bus; sr1_val = s1; sr2_val = s2; clear_req = clr;
        e.n1 = m_regs[s1];
        e.n2 = m_regs[s2];
        e.e1 = (!m_busy && ld && dr == s1) ? bus : m_regs[s1];
        e.e2 = (!m_busy && ld && dr == s2) ? bus : m_regs[s2];
        e.busy = m_busy;
        e.drop = m_drop;
        e.dirty = m_dirty;
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        checkOutput("sr1_byp", {16'h0, byp_sr1}, {16'h0, got.e1});
        checkOutput("sr2_byp", {16'h0, byp_sr2}, {16'h0, got.e2});
        checkOutput("sr1_nob", {16'h0, nob_sr1}, {16'h0, got.n1});
        checkOutput("sr2_nob", {16'h0, nob_sr2}, {16'h0, got.n2});
        checkOutput("busy",    {31'h0, byp_busy}, {31'h0, got.busy});
        checkOutput("drop",    {31'h0, byp_drop}, {31'h0, got.drop});
        checkOutput("dirty",   {24'h0, byp_dirty}, {24'h0, got.dirty});
        checkOutput("dirty_nob", {24'h0, nob_dirty}, {24'h0, got.dirty});
        if (byp_busy) busy_count++;
        @(posedge clk);
        if (m_busy) begin
            m_regs[m_ptr] = 16'h0000;
            m_dirty[m_ptr] = 1'b0;
            if (ld) m_drop = 1'b1;
            if (m_ptr == 7) m_busy = 1'b0;
            m_ptr = (m_ptr + 1) % 8;
        end else begin
            if (ld) begin
                m_regs[dr] = bus;
                m_dirty[dr] = 1'b1;
            end
            if (clr) begin
                m_busy = 1'b1;
                m_ptr  = 0;
                m_drop = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 3'd0, 16'h0, 3'(k), 3'(k + 1), 1'b0);
    endtask

    initial begin
        reset = 1'b1; ld_reg = 1'b0; bus_val = 16'h0; dr_val = 3'd0;
        sr1_val = 3'd0; sr2_val = 3'd0; clear_req = 1'b0;
        modelReset();
        #12;
        checkOutput("rst_sr1", {16'h0, byp_sr1}, 32'h0);
        checkOutput("rst_busy", {31'h0, byp_busy}, 32'h0);
        checkOutput("rst_dirty", {24'h0, byp_dirty}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Write then read back
        applyStimulus(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b0);
        #1;
        checkOutput("t1_sr1", {16'h0, byp_sr1}, 32'h0000BEEF);
        checkOutput("t1_sr2", {16'h0, nob_sr2}, 32'h0000BEEF);
        checkOutput("t1_dirty", {24'h0, byp_dirty}, 32'h08);

        // Same-cycle bypass versus stored value
        applyStimulus(1'b1, 3'd5, 16'h1234, 3'd5, 3'd3, 1'b0);
        idle(1);

        // Fill, then full sweep
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 3'(i), 3'(7 - i), 1'b0);
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd7, 1'b1);
        busy_count = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'd0, 16'h0, 3'(i), 3'd7, 1'b0);
        idle(1);
        checkOutput("t3_busy_cycles", busy_count, 32'd8);
        checkOutput("t3_dirty", {24'h0, byp_dirty}, 32'h0);
        checkOutput("t3_drop", {31'h0, byp_drop}, 32'h0);

        // Dropped write during sweep, then Drop_Flag cleared by next request
        applyStimulus(1'b1, 3'd7, 16'h5555, 3'd7, 3'd7, 1'b1);
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd7, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd7, 16'hAAAA, 3'd7, 3'd7, 1'b0);
        idle(8);
        checkOutput("t4_drop", {31'h0, byp_drop}, 32'h1);
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd7, 3'd7, 1'b0);
        checkOutput("t4_r7", {16'h0, byp_sr1}, 32'h0);
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd7, 3'd7, 1'b1);
        idle(9);
        checkOutput("t4_drop_clr", {31'h0, byp_drop}, 32'h0);

        // Async reset in the middle of a sweep
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), 16'(16'h0F0F + i), 3'd6, 3'd7, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd6, 3'd7, 1'b1);
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd6, 3'd7, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd6, 3'd7, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd6, 3'd7, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_busy", {31'h0, byp_busy}, 32'h0);
        checkOutput("t5_sr1", {16'h0, byp_sr1}, 32'h0);
        checkOutput("t5_sr2", {16'h0, byp_sr2}, 32'h0);
        checkOutput("t5_dirty", {24'h0, byp_dirty}, 32'h0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1);
        busy_count = 0;
        idle(10);
        checkOutput("t5_busy_cycles", busy_count, 32'd8);

        // Repeated request mid-sweep must not extend it
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1);
        busy_count = 0;
        idle(3);
        applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1);
        idle(7);
        checkOutput("t6_busy_cycles", busy_count, 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
